// File: rtl/div_pkg.sv
// Shared types and constants for the iterative signed divider.
package div_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIX  = 2'd2
  } div_state_t;

  localparam int DIV_WIDTH   = 32;
  localparam int DIV_LATENCY = DIV_WIDTH + 1;
  localparam int DIV_CNT_W   = 6;

endpackage

// File: rtl/div_step.sv
// One combinational restoring-division iteration on unsigned magnitudes.
module div_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] rem,
  input  logic [WIDTH-1:0] quo,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] rem_next,
  output logic [WIDTH-1:0] quo_next
);

  logic [WIDTH:0] shifted;
  logic [WIDTH:0] diff;

  always_comb begin
    shifted = {rem, quo[WIDTH-1]};
    // rem < divisor <= 2^(WIDTH-1), so shifted never reaches 2^WIDTH and diff[WIDTH] is the sign.
    diff = shifted - {1'b0, divisor};
    if (!diff[WIDTH]) begin
      rem_next = diff[WIDTH-1:0];
      quo_next = {quo[WIDTH-2:0], 1'b1};
    end else begin
      rem_next = shifted[WIDTH-1:0];
      quo_next = {quo[WIDTH-2:0], 1'b0};
    end
  end

endmodule

// File: rtl/div_iter.sv
// Iterative signed divider, fixed WIDTH+1 edge latency from start to RDY.
// Optional signed remainder output enabled by defining DIV_REMAINDER_EN.
module div_iter
  import div_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic             cpu_clock,
  input  logic             reset_n,
  input  logic             ctrl_div,
  input  logic [WIDTH-1:0] data_operandA,
  input  logic [WIDTH-1:0] data_operandB,
  output logic [WIDTH-1:0] data_result,
`ifdef DIV_REMAINDER_EN
  output logic [WIDTH-1:0] data_remainder,
`endif
  output logic             data_exception,
  output logic             data_resultRDY,
  output logic             div_busy
);

  div_state_t state_q, state_d;
  logic [DIV_CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] divisor_q, divisor_d;
  logic             neg_q, neg_d;
  logic             zero_q, zero_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             exc_q, exc_d;
  logic             rdy_q, rdy_d;
  logic             busy_q, busy_d;
`ifdef DIV_REMAINDER_EN
  logic             sign_a_q, sign_a_d;
  logic [WIDTH-1:0] remainder_q, remainder_d;
`endif

  logic [WIDTH-1:0] abs_a, abs_b;
  logic [WIDTH-1:0] step_rem, step_quo;

  assign abs_a = data_operandA[WIDTH-1] ? -data_operandA : data_operandA;
  assign abs_b = data_operandB[WIDTH-1] ? -data_operandB : data_operandB;

  div_step #(.WIDTH(WIDTH)) u_step (
    .rem      (rem_q),
    .quo      (quo_q),
    .divisor  (divisor_q),
    .rem_next (step_rem),
    .quo_next (step_quo)
  );

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    rem_d     = rem_q;
    quo_d     = quo_q;
    divisor_d = divisor_q;
    neg_d     = neg_q;
    zero_d    = zero_q;
    result_d  = result_q;
    exc_d     = exc_q;
    rdy_d     = 1'b0;
`ifdef DIV_REMAINDER_EN
    sign_a_d    = sign_a_q;
    remainder_d = remainder_q;
`endif

    // A start in any state aborts whatever is in flight and begins afresh.
    if (ctrl_div) begin
      state_d   = RUN;
      cnt_d     = '0;
      rem_d     = '0;
      quo_d     = abs_a;
      divisor_d = abs_b;
      neg_d     = data_operandA[WIDTH-1] ^ data_operandB[WIDTH-1];
      zero_d    = (data_operandB == '0);
`ifdef DIV_REMAINDER_EN
      sign_a_d  = data_operandA[WIDTH-1];
`endif
    end else begin
      case (state_q)
        RUN: begin
          rem_d = step_rem;
          quo_d = step_quo;
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == DIV_CNT_W'(WIDTH-1)) state_d = FIX;
        end
        FIX: begin
          result_d = zero_q ? '0 : (neg_q ? -quo_q : quo_q);
          exc_d    = zero_q;
          rdy_d    = 1'b1;
          state_d  = IDLE;
`ifdef DIV_REMAINDER_EN
          remainder_d = zero_q ? '0 : (sign_a_q ? -rem_q : rem_q);
`endif
        end
        default: ;
      endcase
    end

    // Busy stays up through the RDY cycle so it spans start edge to RDY-drop edge.
    busy_d = (state_d != IDLE) || (state_q == FIX);
  end

  always_ff @(posedge cpu_clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      rem_q       <= '0;
      quo_q       <= '0;
      divisor_q   <= '0;
      neg_q       <= 1'b0;
      zero_q      <= 1'b0;
      result_q    <= '0;
      exc_q       <= 1'b0;
      rdy_q       <= 1'b0;
      busy_q      <= 1'b0;
`ifdef DIV_REMAINDER_EN
      sign_a_q    <= 1'b0;
      remainder_q <= '0;
`endif
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      rem_q       <= rem_d;
      quo_q       <= quo_d;
      divisor_q   <= divisor_d;
      neg_q       <= neg_d;
      zero_q      <= zero_d;
      result_q    <= result_d;
      exc_q       <= exc_d;
      rdy_q       <= rdy_d;
      busy_q      <= busy_d;
`ifdef DIV_REMAINDER_EN
      sign_a_q    <= sign_a_d;
      remainder_q <= remainder_d;
`endif
    end
  end

  assign data_result    = result_q;
  assign data_exception = exc_q;
  assign data_resultRDY = rdy_q;
  assign div_busy       = busy_q;
`ifdef DIV_REMAINDER_EN
  assign data_remainder = remainder_q;
`endif

endmodule

// File: tb/tb_div_iter.sv
// Directed self-checking bench for div_iter; checks latency, values and abort/reset cases.
module tb_div_iter;

  logic        cpu_clock = 1'b0;
  logic        reset_n;
  logic        ctrl_div;
  logic [31:0] data_operandA;
  logic [31:0] data_operandB;
  logic [31:0] data_result;
  logic        data_exception;
  logic        data_resultRDY;
  logic        div_busy;
`ifdef DIV_REMAINDER_EN
  logic [31:0] data_remainder;
`endif

  int vectors = 0;
  int miscompares = 0;

  always #5 cpu_clock = ~cpu_clock;

  div_iter dut (
    .cpu_clock      (cpu_clock),
    .reset_n        (reset_n),
    .ctrl_div       (ctrl_div),
    .data_operandA  (data_operandA),
    .data_operandB  (data_operandB),
    .data_result    (data_result),
`ifdef DIV_REMAINDER_EN
    .data_remainder (data_remainder),
`endif
    .data_exception (data_exception),
    .data_resultRDY (data_resultRDY),
    .div_busy       (div_busy)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
    $display("check %-18s observed %h expected %h", tag, obs, exp);
  endtask

  // Called at a falling edge; ctrl_div is high for n rising edges, returns at the falling edge after the last.
  task automatic do_start(input logic [31:0] a, input logic [31:0] b, input int n);
    data_operandA = a;
    data_operandB = b;
    ctrl_div = 1'b1;
    repeat (n) @(negedge cpu_clock);
    ctrl_div = 1'b0;
  endtask

  // Watches edges E1..E34 after the last start edge; RDY must appear only after E33.
  task automatic watch(input string tag, input logic [31:0] exp_q, input logic exp_exc,
                       input logic [31:0] exp_rem);
    int rdy_cnt = 0;
    int rdy_at  = -1;
    chk({tag, ".busy0"}, {31'd0, div_busy}, 32'd1);
    for (int k = 1; k <= 34; k++) begin
      @(negedge cpu_clock);
      if (data_resultRDY) begin
        rdy_cnt++;
        rdy_at = k;
      end
      if (k == 33) begin
        chk({tag, ".result"}, data_result, exp_q);
        chk({tag, ".exc"}, {31'd0, data_exception}, {31'd0, exp_exc});
        chk({tag, ".busy33"}, {31'd0, div_busy}, 32'd1);
`ifdef DIV_REMAINDER_EN
        chk({tag, ".rem"}, data_remainder, exp_rem);
`else
        if (exp_rem !== 32'hxxxxxxxx) ; // remainder not present in this build
`endif
      end
      if (k == 34) chk({tag, ".busy34"}, {31'd0, div_busy}, 32'd0);
    end
    chk({tag, ".rdy_cnt"}, rdy_cnt, 32'd1);
    chk({tag, ".rdy_at"}, rdy_at, 32'd33);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int rdy_seen;
    reset_n = 1'b0;
    ctrl_div = 1'b0;
    data_operandA = '0;
    data_operandB = '0;
    repeat (3) @(negedge cpu_clock);
    chk("reset.result", data_result, 32'd0);
    chk("reset.exc", {31'd0, data_exception}, 32'd0);
    chk("reset.rdy", {31'd0, data_resultRDY}, 32'd0);
    chk("reset.busy", {31'd0, div_busy}, 32'd0);
    reset_n = 1'b1;
    @(negedge cpu_clock);

    do_start(32'd100, 32'd7, 1);
    watch("100/7", 32'd14, 1'b0, 32'd2);

    do_start(-32'sd100, 32'd7, 1);
    watch("-100/7", 32'hFFFFFFF2, 1'b0, 32'hFFFFFFFE);

    do_start(32'd100, -32'sd7, 1);
    watch("100/-7", 32'hFFFFFFF2, 1'b0, 32'd2);

    do_start(-32'sd7, 32'd2, 1);
    watch("-7/2", 32'hFFFFFFFD, 1'b0, 32'hFFFFFFFF);

    do_start(32'd5, 32'd0, 1);
    watch("5/0", 32'd0, 1'b1, 32'd0);

    do_start(32'd9, 32'd3, 1);
    watch("9/3", 32'd3, 1'b0, 32'd0);

    do_start(32'h80000000, 32'hFFFFFFFF, 1);
    watch("min/-1", 32'h80000000, 1'b0, 32'd0);

    do_start(32'h80000000, 32'd1, 1);
    watch("min/1", 32'h80000000, 1'b0, 32'd0);

    // Start held for three edges: result counts from the last high edge.
    do_start(32'd1000, 32'd10, 3);
    watch("hold", 32'd100, 1'b0, 32'd0);

    // Restart at E10 with 50/5; the aborted 100/7 must not produce RDY.
    do_start(32'd100, 32'd7, 1);
    rdy_seen = 0;
    repeat (9) begin
      @(negedge cpu_clock);
      if (data_resultRDY) rdy_seen++;
    end
    do_start(32'd50, 32'd5, 1);
    chk("restart.pre_rdy", rdy_seen, 32'd0);
    watch("restart", 32'd10, 1'b0, 32'd0);

    // Asynchronous reset mid-run at E20.
    do_start(32'd100, 32'd7, 1);
    repeat (19) @(negedge cpu_clock);
    #2 reset_n = 1'b0;
    #1;
    chk("areset.result", data_result, 32'd0);
    chk("areset.busy", {31'd0, div_busy}, 32'd0);
    chk("areset.exc", {31'd0, data_exception}, 32'd0);
    repeat (2) @(negedge cpu_clock);
    reset_n = 1'b1;
    rdy_seen = 0;
    repeat (40) begin
      @(negedge cpu_clock);
      if (data_resultRDY) rdy_seen++;
    end
    chk("areset.no_rdy", rdy_seen, 32'd0);

    do_start(32'd100, 32'd7, 1);
    watch("post_reset", 32'd14, 1'b0, 32'd2);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
